// File: rtl/mb_microseq.sv
// rtl/mb_microseq.sv - microcoded sequencer: 16-entry register file, ALU, flag branching, step watchdog
module mb_microseq #(
    parameter int DATA_W    = 16,
    parameter int MAX_STEPS = 1024
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic [7:0]        START_ADDR,
    input  logic              HOST_WE,
    input  logic [3:0]        HOST_ADDR,
    input  logic [DATA_W-1:0] HOST_WDATA,
    output logic [DATA_W-1:0] HOST_RDATA,
    output logic [7:0]        ROM_ADDR,
    input  logic [23:0]       ROM_DATA,
    output logic              STOP,
    output logic              DONE,
    output logic              ERR,
    output logic [2:0]        FLAGS
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC
    } state_t;

    localparam logic [15:0] STEP_LIMIT = 16'(MAX_STEPS);

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [2:0]  flags_q, flags_d;
    logic [15:0] step_q, step_d;

    logic [DATA_W-1:0] rf_q [16];
    logic              rf_we;
    logic [3:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    logic        mw_halt;
    logic [1:0]  mw_br;
    logic [2:0]  mw_op;
    logic [3:0]  mw_a;
    logic [3:0]  mw_b;
    logic [7:0]  mw_tgt;
    logic        unused_rsvd;

    assign mw_halt     = ROM_DATA[23];
    assign mw_br       = ROM_DATA[22:21];
    assign mw_op       = ROM_DATA[20:18];
    assign mw_a        = ROM_DATA[17:14];
    assign mw_b        = ROM_DATA[13:10];
    assign mw_tgt      = ROM_DATA[7:0];
    assign unused_rsvd = ^ROM_DATA[9:8];

    logic [DATA_W-1:0] opa, opb, alu_res;
    logic              alu_c, alu_wr, br_taken;
    logic [15:0]       step_next;

    assign opa       = rf_q[mw_a];
    assign opb       = rf_q[mw_b];
    assign step_next = step_q + 16'd1;

    // Carry defaults to the held C so logic/move ops leave it untouched.
    always_comb begin
        alu_res = '0;
        alu_c   = flags_q[0];
        alu_wr  = 1'b1;
        case (mw_op)
            3'd0: {alu_c, alu_res} = {1'b0, opa} + {1'b0, opb};
            3'd1: {alu_c, alu_res} = {1'b0, opa} - {1'b0, opb};
            3'd2: alu_res = opa & opb;
            3'd3: alu_res = opa | opb;
            3'd4: alu_res = opb;
            3'd5: alu_res = {opb[DATA_W-1], opb[DATA_W-1:1]};
            3'd6: begin
                alu_res = {opb[DATA_W-2:0], 1'b0};
                alu_c   = opb[DATA_W-1];
            end
            default: alu_wr = 1'b0;
        endcase
    end

    // Branches test the flags held before this instruction's own result.
    always_comb begin
        case (mw_br)
            2'b01:   br_taken = 1'b1;
            2'b10:   br_taken = flags_q[2];
            2'b11:   br_taken = flags_q[1];
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        done_d   = 1'b0;
        err_d    = err_q;
        flags_d  = flags_q;
        step_d   = step_q;
        rf_we    = 1'b0;
        rf_waddr = HOST_ADDR;
        rf_wdata = HOST_WDATA;
        case (state_q)
            S_IDLE: begin
                rf_we = HOST_WE;
                if (START) begin
                    err_d   = 1'b0;
                    step_d  = '0;
                    pc_d    = START_ADDR;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                if (alu_wr) begin
                    rf_we    = 1'b1;
                    rf_waddr = mw_a;
                    rf_wdata = alu_res;
                    flags_d  = {alu_res[DATA_W-1], (alu_res == '0), alu_c};
                end
                step_d = step_next;
                if (mw_halt) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (step_next == STEP_LIMIT) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    pc_d    = br_taken ? mw_tgt : pc_q + 8'd1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            flags_q <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
            err_q   <= err_d;
            flags_q <= flags_d;
            step_q  <= step_d;
        end
    end

    // Register file is not reset; writes are suppressed while reset is held.
    always_ff @(posedge CLK) begin
        if (rf_we && RST_N) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

    assign HOST_RDATA = rf_q[HOST_ADDR];
    assign ROM_ADDR   = pc_q;
    assign STOP       = (state_q == S_IDLE);
    assign DONE       = done_q;
    assign ERR        = err_q;
    assign FLAGS      = flags_q;

endmodule
